pc_unit: RTL

Program-counter stage of the multicycle datapath. Selects the next PC from the PC-source candidates: the sequential ALU result, the registered branch target, the jump address formed from PC[31:28] and the instruction's 26-bit index, the EPC, the exception vector, or register A. Evaluates the branch condition from ALU flags, holds the PC and EPC registers, and drives the current PC back to the memory address mux and to the jump-address former.

---
 rtl/pc_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC select, branch evaluation,
// PC/EPC registers and one-cycle status pulses.
module pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] EPC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_write,
   input  logic        pc_write_cond,
   input  logic [1:0]  branch_op,
   input  logic        zero,
   input  logic        gt,
   input  logic        lt,
   input  logic [2:0]  pc_source,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_out,
   input  logic [31:0] jump_address,
   input  logic [31:0] reg_a,
   input  logic [7:0]  exc_vector,
   input  logic        epc_write,
   output logic [31:0] pc,
   output logic [31:0] epc,
   output logic        pc_updated,
   output logic        branch_taken,
   output logic        misaligned,
   output logic        bad_source
);

   logic        cond;
   logic        write;
   logic        src_ok;
   logic [31:0] target;

   always_comb begin
      cond = 1'b0;
      unique case (branch_op)
         2'b00: cond = zero;
         2'b01: cond = !zero;
         2'b10: cond = zero | lt;
         2'b11: cond = gt;
      endcase
   end

   always_comb begin
      target = pc;
      src_ok = 1'b1;
      case (pc_source)
         3'b000:  target = alu_result;
         3'b001:  target = alu_out;
         3'b010:  target = jump_address;
         3'b011:  target = epc;
         3'b100:  target = {24'h0, exc_vector};
         3'b101:  target = reg_a;
         default: src_ok = 1'b0;
      endcase
   end

   assign write = pc_write | (pc_write_cond & cond);

   // EPC read in the mux is the pre-edge value, so an EPC return
   // and an EPC capture on the same edge swap cleanly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc           <= RESET_PC;
         epc          <= EPC_RESET;
         pc_updated   <= 1'b0;
         branch_taken <= 1'b0;
         misaligned   <= 1'b0;
         bad_source   <= 1'b0;
      end else begin
         pc_updated   <= 1'b0;
         branch_taken <= 1'b0;
         misaligned   <= 1'b0;
         bad_source   <= 1'b0;
         if (write) begin
            if (src_ok) begin
               pc           <= target;
               pc_updated   <= 1'b1;
               branch_taken <= !pc_write;
               misaligned   <= |target[1:0];
            end else begin
               bad_source   <= 1'b1;
            end
         end
         if (epc_write)
            epc <= alu_result;
      end
   end

endmodule
